// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that hands bytes from four requesters to one UART transmitter, with a watchdog.
// Define UART_ARB_LOCK_EN to let the owner keep the transmitter for up to LOCK_MAX consecutive bytes.
module uart_tx_arb #(
    parameter int WDOG     = 2000,
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_data,
    output logic [3:0]  o_ack,
    output logic [3:0]  o_grant,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_err,
    output logic [1:0]  o_dbg_state
);
    // Handshake: a requester raises i_req[n] with its byte on i_data[8n+7:8n] and holds both
    // until o_ack[n]; i_tx_ready high means the transmitter can take the byte on o_tx_start.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(WDOG - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  own_q, own_d;
    logic [15:0] wdog_q, wdog_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  grant_q, grant_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;

    logic [1:0]  rr_win;
    logic        rr_found;
    logic [1:0]  win;
    logic        lock_hit;
    logic        expire;
    logic        finish;

`ifdef UART_ARB_LOCK_EN
    localparam logic [15:0] LOCK_LIM = 16'(LOCK_MAX);

    logic [15:0] burst_q, burst_d;
    logic        lock_q, lock_d;

    assign lock_hit = lock_q && i_req[own_q];
`else
    assign lock_hit = 1'b0;

    // LOCK_MAX has no effect when the lock feature is not built.
    if (LOCK_MAX < 1) begin : g_lock_max_ignored
    end
`endif

    // First requester at or after ptr, wrapping 3 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!rr_found && i_req[ptr_q + 2'(i)]) begin
                rr_found = 1'b1;
                rr_win   = ptr_q + 2'(i);
            end
        end
    end

    assign win = lock_hit ? own_q : rr_win;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        wdog_d  = wdog_q;
        ack_d   = 4'b0000;
        start_d = 1'b0;
        err_d   = 1'b0;
        grant_d = grant_q;
        data_d  = data_q;
        expire  = 1'b0;
        finish  = 1'b0;
`ifdef UART_ARB_LOCK_EN
        burst_d = burst_q;
        lock_d  = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tx_ready && (i_req != 4'b0000)) begin
                    state_d = WAIT_BUSY;
                    own_d   = win;
                    wdog_d  = 16'd0;
                    ack_d   = 4'b0001 << win;
                    grant_d = 4'b0001 << win;
                    start_d = 1'b1;
                    data_d  = i_data[8*win +: 8];
`ifdef UART_ARB_LOCK_EN
                    burst_d = lock_hit ? burst_q + 16'd1 : 16'd1;
                    lock_d  = 1'b0;
`endif
                end
            end
            WAIT_BUSY, WAIT_DONE: begin
                wdog_d = wdog_q + 16'd1;
                if (wdog_q == WDOG_LAST) begin
                    expire = 1'b1;
                    err_d  = 1'b1;
                end else if (state_q == WAIT_BUSY) begin
                    if (!i_tx_ready) begin
                        state_d = WAIT_DONE;
                    end
                end else if (i_tx_ready) begin
                    finish = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (expire || finish) begin
            state_d = IDLE;
            grant_d = 4'b0000;
            data_d  = 8'h00;
            ptr_d   = own_q + 2'd1;
`ifdef UART_ARB_LOCK_EN
            lock_d  = 1'b0;
            burst_d = 16'd0;
            // A clean finish with the owner still requesting keeps the lock and the pointer.
            if (finish && i_req[own_q] && (burst_q < LOCK_LIM)) begin
                ptr_d   = ptr_q;
                lock_d  = 1'b1;
                burst_d = burst_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            own_q   <= 2'd0;
            wdog_q  <= 16'd0;
            ack_q   <= 4'b0000;
            grant_q <= 4'b0000;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
`ifdef UART_ARB_LOCK_EN
            burst_q <= 16'd0;
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            wdog_q  <= wdog_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            start_q <= start_d;
            err_q   <= err_d;
            data_q  <= data_d;
`ifdef UART_ARB_LOCK_EN
            burst_q <= burst_d;
            lock_q  <= lock_d;
`endif
        end
    end

    assign o_ack       = ack_q;
    assign o_grant     = grant_q;
    assign o_tx_start  = start_q;
    assign o_tx_data   = data_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed plus randomized bench for uart_tx_arb, checked against a transaction-level arbitration model.
module tb_uart_tx_arb;
    localparam int WDOG     = 20;
    localparam int LOCK_MAX = 3;
`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [3:0]  o_ack;
    logic [3:0]  o_grant;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_err;
    logic [1:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_arb #(.WDOG(WDOG), .LOCK_MAX(LOCK_MAX)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_err      (o_err),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // reference model: arbitration state kept as plain integers
    int        m_ptr, m_own, m_burst;
    bit        m_lock;
    logic [1:0] exp_q[$];
    logic [7:0] exp_data;
    int        cur_w;
    int        obs_w;
    logic [1:0] idle_code;

    function automatic logic [3:0] onehot(int w);
        logic [3:0] one;
        one = 4'b0001;
        return one << w;
    endfunction

    function automatic int model_pick(logic [3:0] req);
        if (LOCK_EN && m_lock && req[m_own]) return m_own;
        for (int k = 0; k < 4; k++)
            if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return 0;
    endfunction

    task automatic model_grant(int w);
        if (m_lock && w == m_own) m_burst++;
        else m_burst = 1;
        m_own  = w;
        m_lock = 0;
    endtask

    task automatic model_done(bit expired, logic [3:0] req_now);
        if (LOCK_EN && !expired && req_now[m_own] && m_burst < LOCK_MAX) begin
            m_lock = 1;
        end else begin
            m_ptr   = (m_own + 1) % 4;
            m_burst = 0;
            m_lock  = 0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_own = 0; m_burst = 0; m_lock = 0;
        exp_q.delete();
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_low(string tag);
        check({tag, "_ack"},   {28'd0, o_ack},      32'd0);
        check({tag, "_grant"}, {28'd0, o_grant},    32'd0);
        check({tag, "_start"}, {31'd0, o_tx_start}, 32'd0);
        check({tag, "_data"},  {24'd0, o_tx_data},  32'd0);
        check({tag, "_err"},   {31'd0, o_err},      32'd0);
    endtask

    task automatic push_expected();
        exp_q.push_back(2'(model_pick(i_req)));
    endtask

    // scoreboard: waits (bounded) for a start pulse and compares it with the queued expectation
    task automatic expect_grant();
        int n;
        logic [1:0] w;
        n = 0;
        while (o_tx_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("start_seen", {31'd0, o_tx_start}, 32'd1);
        w = 2'd0;
        if (exp_q.size() != 0) w = exp_q.pop_front();
        cur_w    = w;
        exp_data = i_data[8*w +: 8];
        obs_w    = 0;
        for (int k = 0; k < 4; k++) if (o_ack[k]) obs_w = k;
        check("ack_onehot",  {28'd0, o_ack},     {28'd0, onehot(w)});
        check("grant_onehot", {28'd0, o_grant},  {28'd0, onehot(w)});
        check("tx_data",     {24'd0, o_tx_data}, {24'd0, exp_data});
        check("dbg_busy", {31'd0, dbg_state != idle_code}, 32'd1);
        model_grant(w);
    endtask

    // transmitter model: goes busy right after the start, stays busy for `busy` cycles
    task automatic finish_byte(int busy, logic [3:0] drop);
        i_tx_ready = 1'b0;
        tick();
        check("start_pulse", {31'd0, o_tx_start}, 32'd0);
        check("ack_pulse",   {28'd0, o_ack},      32'd0);
        check("grant_hold",  {28'd0, o_grant},    {28'd0, onehot(cur_w)});
        i_req  = i_req & ~drop;
        i_data = $urandom;
        for (int i = 1; i < busy; i++) begin
            tick();
            check("data_hold", {24'd0, o_tx_data}, {24'd0, exp_data});
        end
        i_tx_ready = 1'b1;
        tick();
        check("grant_clear", {28'd0, o_grant}, 32'd0);
        check("err_quiet",   {31'd0, o_err},   32'd0);
        model_done(1'b0, i_req);
    endtask

    int spec_order[8];
    int obs_order[8];
    int w0;

    initial begin
        rstn = 1'b1; i_req = 4'b0000; i_data = 32'd0; i_tx_ready = 1'b0;
        model_reset();
        #3 rstn = 1'b0;
        #1;
        check_all_low("reset");
        idle_code = dbg_state;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check_all_low("post_reset_idle");

        // transmitter not ready: no grant for 50 cycles, then grant on the next cycle
        i_req  = 4'b0001;
        i_data = $urandom;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("notready_start", {31'd0, o_tx_start}, 32'd0);
            check("notready_ack",   {28'd0, o_ack},      32'd0);
        end
        i_tx_ready = 1'b1;
        push_expected();
        tick();
        check("ready_next_cycle", {31'd0, o_tx_start}, 32'd1);
        expect_grant();
        finish_byte(3, 4'b0001);

        // single requester 2 with byte 8'hA5
        i_data = $urandom;
        i_data[23:16] = 8'hA5;
        i_req = 4'b0100;
        push_expected();
        expect_grant();
        check("req2_data_a5", {24'd0, o_tx_data}, 32'h0000_00A5);
        check("req2_ack",     {28'd0, o_ack},     32'h0000_0004);
        finish_byte(3, 4'b0100);

        // requester 1 drops after its ack: no second grant
        i_data = $urandom;
        i_req  = 4'b0010;
        push_expected();
        expect_grant();
        finish_byte(3, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_regrant_start", {31'd0, o_tx_start}, 32'd0);
            check("idle_grant",       {28'd0, o_grant},    32'd0);
        end

        // reset while in WAIT_DONE
        i_data = $urandom;
        i_req  = 4'b0100;
        push_expected();
        expect_grant();
        i_tx_ready = 1'b0;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        check_all_low("async_reset");
        model_reset();
        i_req = 4'b1000;
        i_data = $urandom;
        i_tx_ready = 1'b1;
        tick();
        rstn = 1'b1;
        push_expected();
        expect_grant();
        check("after_reset_req3", {28'd0, o_ack}, 32'h0000_0008);
        finish_byte(2, 4'b1000);

        // all four requesting for eight bytes
        if (LOCK_EN) spec_order = '{0, 0, 0, 1, 1, 1, 2, 2};
        else         spec_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        i_req = 4'b1111;
        for (int b = 0; b < 8; b++) begin
            push_expected();
            expect_grant();
            obs_order[b] = obs_w;
            finish_byte($urandom_range(1, 4), (b == 7) ? 4'b1111 : 4'b0000);
        end
        for (int b = 0; b < 8; b++)
            check($sformatf("order_%0d", b), obs_order[b], spec_order[b]);

        // watchdog: transmitter never goes busy
        i_req  = 4'b1111;
        i_data = $urandom;
        push_expected();
        expect_grant();
        w0 = cur_w;
        for (int k = 1; k < WDOG; k++) begin
            tick();
            check("wdog_quiet", {31'd0, o_err}, 32'd0);
        end
        tick();
        check("wdog_err",   {31'd0, o_err},   32'd1);
        check("wdog_grant", {28'd0, o_grant}, 32'd0);
        model_done(1'b1, i_req);
        push_expected();
        tick();
        check("wdog_err_pulse", {31'd0, o_err}, 32'd0);
        expect_grant();
        check("wdog_next_owner", {28'd0, o_ack}, {28'd0, onehot((w0 + 1) % 4)});
        finish_byte(2, 4'b1111);

        // randomized traffic
        for (int t = 0; t < 16; t++) begin
            i_req  = 4'($urandom_range(1, 15));
            i_data = $urandom;
            push_expected();
            expect_grant();
            finish_byte($urandom_range(1, 5), ($urandom_range(0, 1) == 1) ? onehot(cur_w) : 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
